// File: rtl/ram_dma.sv
// Single-channel RAM-to-RAM copy engine: READ/WRITE ping-pong over one RAM port.
// Optional fill mode (constant write, no reads) is enabled by defining RAM_DMA_FILL_EN.
module ram_dma #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W:0]   len,
`ifdef RAM_DMA_FILL_EN
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_value,
`endif
    output logic              busy,
    output logic              done,
    output logic              mem_load,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [ADDR_W:0] ONE = 1;

    state_t            state, state_n;
    logic [ADDR_W-1:0] src_r, dst_r;
    logic [ADDR_W:0]   len_r, i;
    logic [DATA_W-1:0] data_r;
    logic              fill_mode;
    logic              start_fill;
    logic              last;

`ifdef RAM_DMA_FILL_EN
    logic fill_r;
    assign fill_mode  = fill_r;
    assign start_fill = fill;
`else
    assign fill_mode  = 1'b0;
    assign start_fill = 1'b0;
`endif

    // i is ADDR_W+1 bits wide so a full 2^ADDR_W-word transfer terminates
    assign last = ((i + ONE) >= len_r);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n     = state;
        busy        = 1'b0;
        done        = 1'b0;
        mem_load    = 1'b0;
        mem_address = '0;
        mem_in      = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0)      state_n = DONE;
                    else if (start_fill) state_n = WRITE;
                    else                state_n = READ;
                end
            end
            READ: begin
                busy        = 1'b1;
                mem_address = src_r + i[ADDR_W-1:0];
                state_n     = WRITE;
            end
            WRITE: begin
                busy        = 1'b1;
                mem_load    = 1'b1;
                mem_address = dst_r + i[ADDR_W-1:0];
                mem_in      = data_r;
                if (last)           state_n = DONE;
                else if (fill_mode) state_n = WRITE;
                else                state_n = READ;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_r  <= '0;
            dst_r  <= '0;
            len_r  <= '0;
            i      <= '0;
            data_r <= '0;
`ifdef RAM_DMA_FILL_EN
            fill_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    src_r <= src;
                    dst_r <= dst;
                    len_r <= len;
                    i     <= '0;
`ifdef RAM_DMA_FILL_EN
                    // fill mode reuses the data register as the constant source
                    fill_r <= fill;
                    if (fill) data_r <= fill_value;
`endif
                end
                READ:    data_r <= mem_out;
                WRITE:   i <= i + ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dma.sv
// Directed bench for ram_dma against a 64x16 RAM model (sync write, comb read).
module tb_ram_dma;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] src = '0, dst = '0;
    logic [ADDR_W:0]   len = '0;
    logic              busy, done, mem_load;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_in, mem_out;
`ifdef RAM_DMA_FILL_EN
    logic              fill = 1'b0;
    logic [DATA_W-1:0] fill_value = '0;
`endif

    logic [DATA_W-1:0] ram [64];
    logic [DATA_W-1:0] snap [64];
    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [DATA_W-1:0] pre_data = '0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_dma #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .src(src), .dst(dst), .len(len),
`ifdef RAM_DMA_FILL_EN
        .fill(fill), .fill_value(fill_value),
`endif
        .busy(busy), .done(done), .mem_load(mem_load),
        .mem_address(mem_address), .mem_in(mem_in), .mem_out(mem_out)
    );

    assign mem_out = ram[mem_address];
    always @(posedge clk) begin
        if (mem_load)    ram[mem_address] <= mem_in;
        else if (pre_we) ram[pre_addr] <= pre_data;
    end

    task automatic preload(input int a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a[ADDR_W-1:0]; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic do_start(input int s, input int d, input int l);
        @(negedge clk);
        start = 1'b1; src = s[ADDR_W-1:0]; dst = d[ADDR_W-1:0]; len = l[ADDR_W:0];
`ifdef RAM_DMA_FILL_EN
        fill = 1'b0;
`endif
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Samples once per cycle; cycle n is the state after the n-th edge (n=1 is the accepting edge).
    task automatic wait_done(output int cycles, output int writes, output int reads);
        cycles = -1; writes = 0; reads = 0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (mem_load) writes++;
            if (busy && !mem_load && !done) reads++;
            if (done) begin cycles = n; break; end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        for (int a = 0; a < 64; a++) preload(a, '0);
        preload(0, 16'h0011); preload(1, 16'h0022);
        preload(2, 16'h0033); preload(3, 16'h0044);
        n_checks++;
        if ({busy, done, mem_load} !== 3'b000 || mem_address !== '0 || mem_in !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b load=%b addr=%0d in=%h, required all 0",
                     busy, done, mem_load, mem_address, mem_in);
        end
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic test_copy;
        int c, w, r;
        do_start(0, 10, 4);
        wait_done(c, w, r);
        n_checks++;
        if (c !== 9) begin n_fail++; $display("FAIL copy_done_cycle: got %0d, required 9", c); end
        n_checks++;
        if (w !== 4) begin n_fail++; $display("FAIL copy_writes: got %0d, required 4", w); end
        for (int k = 0; k < 4; k++) begin
            logic [DATA_W-1:0] exp;
            exp = DATA_W'((k + 1) * 16'h0011);
            n_checks++;
            if (ram[10+k] !== exp) begin
                n_fail++; $display("FAIL copy_data[%0d]: got %h, required %h", 10+k, ram[10+k], exp);
            end
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL copy_done_pulse: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_len0;
        int c, w, r;
        bit same;
        for (int a = 0; a < 64; a++) snap[a] = ram[a];
        do_start(5, 20, 0);
        wait_done(c, w, r);
        n_checks++;
        if (c !== 1) begin n_fail++; $display("FAIL len0_done_cycle: got %0d, required 1", c); end
        n_checks++;
        if (w !== 0 || r !== 0) begin
            n_fail++; $display("FAIL len0_activity: writes=%0d reads=%0d, required 0 0", w, r);
        end
        @(negedge clk);
        same = 1;
        for (int a = 0; a < 64; a++) if (ram[a] !== snap[a]) same = 0;
        n_checks++;
        if (!same || busy !== 1'b0) begin
            n_fail++; $display("FAIL len0_ram_unchanged: same=%0d busy=%b, required 1 0", same, busy);
        end
    endtask

    task automatic test_wrap;
        int c, w, r;
        preload(62, 16'hAAAA); preload(63, 16'hBBBB);
        do_start(62, 66 % 64, 3);
        wait_done(c, w, r);
        n_checks++;
        if (c !== 7 || w !== 3) begin
            n_fail++; $display("FAIL wrap_timing: cycles=%0d writes=%0d, required 7 3", c, w);
        end
        n_checks++;
        if (ram[2] !== 16'hAAAA || ram[3] !== 16'hBBBB || ram[4] !== 16'h0011) begin
            n_fail++; $display("FAIL wrap_data: got %h %h %h, required aaaa bbbb 0011", ram[2], ram[3], ram[4]);
        end
    endtask

    task automatic test_busy_reset;
        for (int k = 0; k < 4; k++) preload(30 + k, DATA_W'(16'h1000 + k));
        for (int k = 0; k < 4; k++) preload(40 + k, '0);
        do_start(30, 40, 4);
        @(negedge clk);                         // cycle 1: READ
        start = 1'b1; len = '0; src = 7; dst = 7;
        @(negedge clk);                         // cycle 2: WRITE
        start = 1'b0;
        n_checks++;
        if (mem_load !== 1'b1 || mem_address !== 6'd40) begin
            n_fail++; $display("FAIL busy_first_write: load=%b addr=%0d, required 1 40", mem_load, mem_address);
        end
        @(negedge clk);                         // cycle 3: READ
        n_checks++;
        if (mem_load !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || mem_address !== 6'd31) begin
            n_fail++; $display("FAIL busy_start_ignored: load=%b busy=%b done=%b addr=%0d, required 0 1 0 31",
                               mem_load, busy, done, mem_address);
        end
        @(negedge clk);                         // cycle 4: second WRITE
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, mem_load} !== 3'b000 || mem_address !== '0 || mem_in !== '0) begin
            n_fail++; $display("FAIL abort_outputs: busy=%b done=%b load=%b addr=%0d in=%h, required all 0",
                               busy, done, mem_load, mem_address, mem_in);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (ram[40] !== 16'h1000 || ram[41] !== 16'h1001 || ram[42] !== '0 || ram[43] !== '0) begin
            n_fail++; $display("FAIL abort_ram: got %h %h %h %h, required 1000 1001 0000 0000",
                               ram[40], ram[41], ram[42], ram[43]);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_overlap;
        int c, w, r;
        preload(0, 16'd1); preload(1, 16'd2); preload(2, 16'd3);
        do_start(0, 1, 2);
        wait_done(c, w, r);
        n_checks++;
        if (c !== 5 || w !== 2) begin
            n_fail++; $display("FAIL overlap_timing: cycles=%0d writes=%0d, required 5 2", c, w);
        end
        n_checks++;
        if (ram[0] !== 16'd1 || ram[1] !== 16'd1 || ram[2] !== 16'd1) begin
            n_fail++; $display("FAIL overlap_data: got %h %h %h, required 0001 0001 0001", ram[0], ram[1], ram[2]);
        end
    endtask

    task automatic test_back_to_back;
        int c, w, r;
        do_start(10, 50, 1);
        wait_done(c, w, r);
        do_start(11, 51, 2);
        wait_done(c, w, r);
        n_checks++;
        if (c !== 5 || w !== 2) begin
            n_fail++; $display("FAIL b2b_timing: cycles=%0d writes=%0d, required 5 2", c, w);
        end
        n_checks++;
        if (ram[50] !== 16'h0011 || ram[51] !== 16'h0022 || ram[52] !== 16'h0033) begin
            n_fail++; $display("FAIL b2b_data: got %h %h %h, required 0011 0022 0033", ram[50], ram[51], ram[52]);
        end
    endtask

`ifdef RAM_DMA_FILL_EN
    task automatic test_fill;
        int c, w, r;
        @(negedge clk);
        start = 1'b1; src = 6'd3; dst = 6'd20; len = 7'd5; fill = 1'b1; fill_value = 16'hBEEF;
        @(posedge clk); #1;
        start = 1'b0; fill = 1'b0;
        wait_done(c, w, r);
        n_checks++;
        if (c !== 6 || w !== 5 || r !== 0) begin
            n_fail++; $display("FAIL fill_timing: cycles=%0d writes=%0d reads=%0d, required 6 5 0", c, w, r);
        end
        for (int k = 20; k < 25; k++) begin
            n_checks++;
            if (ram[k] !== 16'hBEEF) begin
                n_fail++; $display("FAIL fill_data[%0d]: got %h, required beef", k, ram[k]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_copy();
        test_len0();
        test_wrap();
        test_busy_reset();
        test_overlap();
        test_back_to_back();
`ifdef RAM_DMA_FILL_EN
        test_fill();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
